// File: rtl/req_arb_node_icache_intc.sv
// Two-channel request arbiter for the instruction-cache interconnect.
// Merges two request channels onto a single downstream port. A small ID FIFO
// remembers which channel issued each accepted request, so that in-order
// responses can be steered back to the right channel.
// Optional feature macro: ICACHE_INTC_RR_ARB_EN. When it is defined, priority
// rotates to the channel that was not granted. When it is undefined, ch0 has
// fixed priority.
module req_arb_node_icache_intc #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ID_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request_ch0_i,
    input  logic                  request_ch1_i,
    input  logic [ADDR_WIDTH-1:0] addr_ch0_i,
    input  logic [ADDR_WIDTH-1:0] addr_ch1_i,
    output logic                  grant_ch0_o,
    output logic                  grant_ch1_o,
    output logic                  request_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic                  grant_i,
    input  logic                  response_i,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  response_ch0_o,
    output logic                  response_ch1_o,
    output logic [DATA_WIDTH-1:0] read_data_ch0_o,
    output logic [DATA_WIDTH-1:0] read_data_ch1_o
);

    localparam int unsigned PTR_W = $clog2(ID_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ID_FIFO_DEPTH);

    logic [ID_FIFO_DEPTH-1:0] id_mem_q;
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic [PTR_W-1:0]         rptr_q, rptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     sel;      // 0 = ch0, 1 = ch1
    logic                     push;
    logic                     pop;
    logic                     head_id;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = id_mem_q[rptr_q];

`ifdef ICACHE_INTC_RR_ARB_EN
    logic prio_q, prio_d;   // channel currently holding priority

    // Select ch1 when it is the only requester, or when both request and ch1 holds priority.
    always_comb begin
        sel    = request_ch1_i & (~request_ch0_i | prio_q);
        prio_d = prio_q;
        if (push) begin
            prio_d = ~sel;
        end
    end

    // Priority register; after reset it points at ch0.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // ch0 has fixed priority; ch1 wins only when it requests alone.
    always_comb begin
        sel = request_ch1_i & ~request_ch0_i;
    end
`endif

    // Downstream request and per-channel grants. A full FIFO blocks issue even if a
    // pop happens in the same cycle.
    always_comb begin
        request_o   = (request_ch0_i | request_ch1_i) & ~fifo_full & ~rst;
        addr_o      = sel ? addr_ch1_i : addr_ch0_i;
        push        = request_o & grant_i;
        grant_ch0_o = push & ~sel;
        grant_ch1_o = push & sel;
    end

    // Response steering. A response that arrives while the FIFO is empty is dropped.
    always_comb begin
        pop             = response_i & ~fifo_empty & ~rst;
        response_ch0_o  = pop & ~head_id;
        response_ch1_o  = pop & head_id;
        read_data_ch0_o = read_data_i;
        read_data_ch1_o = read_data_i;
    end

    // FIFO pointer and occupancy next state. The pointers wrap naturally because
    // the depth is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO control state. Reset discards every outstanding ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // ID storage. It needs no reset because entries are only read while the
    // occupancy count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_req_arb_node_icache_intc.sv
// Directed self-checking bench for req_arb_node_icache_intc (default parameters).
// Inputs are driven 2 ns after each rising edge. Combinational outputs are
// sampled 1 ns later, well away from the next edge.
module tb_req_arb_node_icache_intc;

`ifdef ICACHE_INTC_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        request_ch0_i, request_ch1_i;
    logic [31:0] addr_ch0_i, addr_ch1_i;
    logic        grant_ch0_o, grant_ch1_o;
    logic        request_o;
    logic [31:0] addr_o;
    logic        grant_i;
    logic        response_i;
    logic [31:0] read_data_i;
    logic        response_ch0_o, response_ch1_o;
    logic [31:0] read_data_ch0_o, read_data_ch1_o;

    int checks;
    int errors;

    req_arb_node_icache_intc #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .ID_FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .request_ch0_i  (request_ch0_i),
        .request_ch1_i  (request_ch1_i),
        .addr_ch0_i     (addr_ch0_i),
        .addr_ch1_i     (addr_ch1_i),
        .grant_ch0_o    (grant_ch0_o),
        .grant_ch1_o    (grant_ch1_o),
        .request_o      (request_o),
        .addr_o         (addr_o),
        .grant_i        (grant_i),
        .response_i     (response_i),
        .read_data_i    (read_data_i),
        .response_ch0_o (response_ch0_o),
        .response_ch1_o (response_ch1_o),
        .read_data_ch0_o(read_data_ch0_o),
        .read_data_ch1_o(read_data_ch1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        request_ch0_i = 1'b0;
        request_ch1_i = 1'b0;
        grant_i       = 1'b0;
        response_i    = 1'b0;
    endtask

    // Outputs stay quiet while reset is held, even with every input active.
    task automatic test_reset();
        rst = 1'b1;
        request_ch0_i = 1'b1; request_ch1_i = 1'b1;
        grant_i = 1'b1; response_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({request_o, grant_ch0_o, grant_ch1_o, response_ch0_o, response_ch1_o} !== 5'b0) begin
                $display("FAIL reset_outputs: got %b expected 00000",
                         {request_o, grant_ch0_o, grant_ch1_o, response_ch0_o, response_ch1_o});
                errors++;
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        // FIFO empty after reset: a response is dropped.
        response_i = 1'b1;
        #1;
        checks++;
        if ({response_ch0_o, response_ch1_o} !== 2'b00) begin
            $display("FAIL reset_fifo_empty: got %b expected 00", {response_ch0_o, response_ch1_o});
            errors++;
        end
        tick();
        idle_inputs();
    endtask

    // Both channels request with no downstream grant; nothing moves.
    task automatic test_stall();
        addr_ch0_i = 32'h111; addr_ch1_i = 32'h222;
        request_ch0_i = 1'b1; request_ch1_i = 1'b1; grant_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (request_o !== 1'b1 || {grant_ch0_o, grant_ch1_o} !== 2'b00 ||
                addr_o !== 32'h111) begin
                $display("FAIL stall_cycle%0d: got req=%b gnt=%b addr=%h expected req=1 gnt=00 addr=00000111",
                         c, request_o, {grant_ch0_o, grant_ch1_o}, addr_o);
                errors++;
            end
            tick();
        end
        idle_inputs();
        response_i = 1'b1;
        #1;
        checks++;
        if ({response_ch0_o, response_ch1_o} !== 2'b00) begin
            $display("FAIL stall_no_push: got %b expected 00", {response_ch0_o, response_ch1_o});
            errors++;
        end
        tick();
        idle_inputs();
    endtask

    // Both channels request every cycle with grant_i=1, then drain and check routing.
    task automatic test_contention();
        logic exp_sel;
        addr_ch0_i = 32'hC0; addr_ch1_i = 32'hC1;
        request_ch0_i = 1'b1; request_ch1_i = 1'b1; grant_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_sel = RR ? c[0] : 1'b0;
            #1;
            checks++;
            if (grant_ch0_o !== ~exp_sel || grant_ch1_o !== exp_sel ||
                addr_o !== (exp_sel ? 32'hC1 : 32'hC0)) begin
                $display("FAIL contention_grant%0d: got gnt0=%b gnt1=%b addr=%h expected gnt0=%b gnt1=%b",
                         c, grant_ch0_o, grant_ch1_o, addr_o, ~exp_sel, exp_sel);
                errors++;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            exp_sel = RR ? c[0] : 1'b0;
            response_i = 1'b1; read_data_i = 32'hD0 + c;
            #1;
            checks++;
            if (response_ch0_o !== ~exp_sel || response_ch1_o !== exp_sel) begin
                $display("FAIL contention_resp%0d: got r0=%b r1=%b expected r0=%b r1=%b",
                         c, response_ch0_o, response_ch1_o, ~exp_sel, exp_sel);
                errors++;
            end
            tick();
        end
        idle_inputs();
    endtask

    // ch1 alone fills the FIFO; issue resumes only after a response has popped an entry.
    task automatic test_full();
        addr_ch1_i = 32'hF1;
        request_ch1_i = 1'b1; grant_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (request_o !== 1'b1 || grant_ch1_o !== 1'b1 || addr_o !== 32'hF1) begin
                $display("FAIL full_fill%0d: got req=%b gnt1=%b addr=%h expected req=1 gnt1=1 addr=000000f1",
                         c, request_o, grant_ch1_o, addr_o);
                errors++;
            end
            tick();
        end
        #1;
        checks++;
        if (request_o !== 1'b0 || {grant_ch0_o, grant_ch1_o} !== 2'b00) begin
            $display("FAIL full_blocked: got req=%b gnt=%b expected req=0 gnt=00",
                     request_o, {grant_ch0_o, grant_ch1_o});
            errors++;
        end
        tick();
        // A pop in the same cycle must not bypass the full condition.
        response_i = 1'b1;
        #1;
        checks++;
        if (request_o !== 1'b0 || grant_ch1_o !== 1'b0 || response_ch1_o !== 1'b1) begin
            $display("FAIL full_no_bypass: got req=%b gnt1=%b r1=%b expected req=0 gnt1=0 r1=1",
                     request_o, grant_ch1_o, response_ch1_o);
            errors++;
        end
        tick();
        response_i = 1'b0;
        #1;
        checks++;
        if (request_o !== 1'b1 || grant_ch1_o !== 1'b1) begin
            $display("FAIL full_resume: got req=%b gnt1=%b expected req=1 gnt1=1", request_o, grant_ch1_o);
            errors++;
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            response_i = 1'b1;
            #1;
            checks++;
            if (response_ch1_o !== 1'b1 || response_ch0_o !== 1'b0) begin
                $display("FAIL full_drain%0d: got r0=%b r1=%b expected r0=0 r1=1",
                         c, response_ch0_o, response_ch1_o);
                errors++;
            end
            tick();
        end
        idle_inputs();
    endtask

    // Issue ch0/ch1/ch0 one at a time, then check that each response goes to its issuer.
    task automatic test_routing();
        logic [31:0] addrs [3];
        logic        chans [3];
        logic [31:0] datas [3];
        addrs[0] = 32'h100; addrs[1] = 32'h200; addrs[2] = 32'h300;
        chans[0] = 1'b0;    chans[1] = 1'b1;    chans[2] = 1'b0;
        datas[0] = 32'hA;   datas[1] = 32'hB;   datas[2] = 32'hC;
        grant_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            request_ch0_i = ~chans[c]; request_ch1_i = chans[c];
            addr_ch0_i = addrs[c]; addr_ch1_i = addrs[c];
            #1;
            checks++;
            if (addr_o !== addrs[c] || grant_ch0_o !== ~chans[c] || grant_ch1_o !== chans[c]) begin
                $display("FAIL route_issue%0d: got addr=%h gnt0=%b gnt1=%b expected addr=%h gnt1=%b",
                         c, addr_o, grant_ch0_o, grant_ch1_o, addrs[c], chans[c]);
                errors++;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            response_i = 1'b1; read_data_i = datas[c];
            #1;
            checks++;
            if (response_ch0_o !== ~chans[c] || response_ch1_o !== chans[c] ||
                read_data_ch0_o !== datas[c] || read_data_ch1_o !== datas[c]) begin
                $display("FAIL route_resp%0d: got r0=%b r1=%b d0=%h d1=%h expected r1=%b data=%h",
                         c, response_ch0_o, response_ch1_o, read_data_ch0_o, read_data_ch1_o,
                         chans[c], datas[c]);
                errors++;
            end
            tick();
        end
        idle_inputs();
    endtask

    // A response with an empty FIFO is dropped, including one in the same cycle as a new grant.
    task automatic test_spurious();
        response_i = 1'b1; read_data_i = 32'h55;
        #1;
        checks++;
        if ({response_ch0_o, response_ch1_o} !== 2'b00) begin
            $display("FAIL spurious_drop: got %b expected 00", {response_ch0_o, response_ch1_o});
            errors++;
        end
        tick();
        request_ch0_i = 1'b1; addr_ch0_i = 32'h400; grant_i = 1'b1; response_i = 1'b1;
        #1;
        checks++;
        if (grant_ch0_o !== 1'b1 || {response_ch0_o, response_ch1_o} !== 2'b00) begin
            $display("FAIL spurious_same_cycle: got gnt0=%b r=%b expected gnt0=1 r=00",
                     grant_ch0_o, {response_ch0_o, response_ch1_o});
            errors++;
        end
        tick();
        idle_inputs();
        response_i = 1'b1;
        #1;
        checks++;
        if (response_ch0_o !== 1'b1 || response_ch1_o !== 1'b0) begin
            $display("FAIL spurious_recover: got r0=%b r1=%b expected r0=1 r1=0",
                     response_ch0_o, response_ch1_o);
            errors++;
        end
        tick();
        idle_inputs();
    endtask

    // A push and a pop in the same cycle leave the FIFO contents consistent.
    task automatic test_back_to_back();
        request_ch0_i = 1'b1; grant_i = 1'b1;
        tick();
        request_ch0_i = 1'b0; request_ch1_i = 1'b1; response_i = 1'b1;
        #1;
        checks++;
        if (grant_ch1_o !== 1'b1 || response_ch0_o !== 1'b1 || response_ch1_o !== 1'b0) begin
            $display("FAIL b2b_push_pop: got gnt1=%b r0=%b r1=%b expected gnt1=1 r0=1 r1=0",
                     grant_ch1_o, response_ch0_o, response_ch1_o);
            errors++;
        end
        tick();
        idle_inputs();
        response_i = 1'b1;
        #1;
        checks++;
        if (response_ch1_o !== 1'b1 || response_ch0_o !== 1'b0) begin
            $display("FAIL b2b_second: got r0=%b r1=%b expected r0=0 r1=1", response_ch0_o, response_ch1_o);
            errors++;
        end
        tick();
        #1;
        checks++;
        if ({response_ch0_o, response_ch1_o} !== 2'b00) begin
            $display("FAIL b2b_empty: got %b expected 00", {response_ch0_o, response_ch1_o});
            errors++;
        end
        tick();
        idle_inputs();
    endtask

    // Reset with three requests outstanding discards them and returns priority to ch0.
    task automatic test_reset_midflight();
        grant_i = 1'b1;
        request_ch0_i = 1'b1; tick();
        request_ch0_i = 1'b0; request_ch1_i = 1'b1; tick();
        request_ch0_i = 1'b1; request_ch1_i = 1'b0; tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr_ch0_i = 32'hAA0; addr_ch1_i = 32'hAA1;
        request_ch0_i = 1'b1; request_ch1_i = 1'b1; grant_i = 1'b0;
        #1;
        checks++;
        if (addr_o !== 32'hAA0 || request_o !== 1'b1) begin
            $display("FAIL midreset_prio: got addr=%h req=%b expected addr=00000aa0 req=1", addr_o, request_o);
            errors++;
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            response_i = 1'b1;
            #1;
            checks++;
            if ({response_ch0_o, response_ch1_o} !== 2'b00) begin
                $display("FAIL midreset_drop%0d: got %b expected 00", c, {response_ch0_o, response_ch1_o});
                errors++;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        addr_ch0_i = '0; addr_ch1_i = '0; read_data_i = '0;
        #2;
        test_reset();
        test_stall();
        test_contention();
        test_full();
        test_routing();
        test_spurious();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_arb_node_icache_intc.md
REQ_ARB_NODE_ICACHE_INTC -- requirements
Module: req_arb_node_icache_intc

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, request address width.
REQ-002 Parameter DATA_WIDTH, default 32, response read-data width.
REQ-003 Parameter ID_FIFO_DEPTH, default 4, maximum number of outstanding requests tracked; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 request_ch0_i / request_ch1_i  in  1  request valid, per channel.
REQ-007 addr_ch0_i / addr_ch1_i  in  ADDR_WIDTH  request address, per channel.
REQ-008 grant_ch0_o / grant_ch1_o  out  1  request accepted this cycle, per channel.
REQ-009 request_o  out  1  arbitrated request toward the next stage.
REQ-010 addr_o  out  ADDR_WIDTH  address of the selected channel.
REQ-011 grant_i  in  1  next stage accepts request_o.
REQ-012 response_i  in  1  response valid from the next stage.
REQ-013 read_data_i  in  DATA_WIDTH  response data.
REQ-014 response_ch0_o / response_ch1_o  out  1  response routed to the owning channel.
REQ-015 read_data_ch0_o / read_data_ch1_o  out  DATA_WIDTH  response data, per channel.

Function
REQ-016 The block SHALL arbitrate two request channels onto one output and SHALL route in-order responses back to the issuing channel.
REQ-017 Selection: if only one channel requests, that channel SHALL be selected; if both request, the channel holding priority SHALL be selected.
REQ-018 request_o SHALL equal (request_ch0_i | request_ch1_i) & ~fifo_full; addr_o SHALL carry the selected channel's address, and SHALL carry ch0's address when no channel requests.
REQ-019 grant_chX_o SHALL be request_o & grant_i & (selected == X), combinationally, with zero latency.
REQ-020 On each accepted handshake (request_o & grant_i), the selected channel ID (1 bit) SHALL be pushed into the ID FIFO.
REQ-021 After each accepted handshake, priority SHALL pass to the channel that was not granted; priority SHALL NOT change in cycles without a handshake.
REQ-022 While the FIFO is full, request_o and both grants SHALL be 0, even if a pop occurs in the same cycle; there is no full-bypass path.
REQ-023 response_i with a non-empty FIFO SHALL pop the FIFO and SHALL assert response_chX_o in the same cycle, where X is the ID at the FIFO head.
REQ-024 read_data_ch0_o and read_data_ch1_o SHALL both equal read_data_i at all times; only the response flags are steered.
REQ-025 response_i while the FIFO is empty SHALL be dropped: both response flags stay 0 and the FIFO is unchanged.
REQ-026 Earliest supported response is the cycle after grant; a same-cycle response to a new grant SHALL be treated as empty-FIFO if no older entry exists.
REQ-027 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; read and write pointers wrap modulo ID_FIFO_DEPTH.
REQ-028 FIFO occupancy SHALL be held in a counter of width clog2(ID_FIFO_DEPTH)+1; full is occupancy == ID_FIFO_DEPTH, and empty is occupancy == 0.

Reset
REQ-029 While rst is high, the FIFO SHALL be emptied, priority SHALL go to ch0, and request_o, both grants, and both response flags SHALL be 0.
REQ-030 Reset asserted with requests outstanding SHALL discard all IDs; responses arriving after reset SHALL be dropped per REQ-025.

Configuration
REQ-031 Macro ICACHE_INTC_RR_ARB_EN: when defined, priority rotates as in REQ-021.
REQ-032 When ICACHE_INTC_RR_ARB_EN is undefined, ch0 SHALL have fixed priority, the priority flop SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Contention: both channels request every cycle with grant_i=1 (RR_ARB_EN defined) -> grants alternate ch0, ch1, ch0, ...; with the macro undefined, ch0 is granted every cycle.
REQ-034 Full: ID_FIFO_DEPTH=4, grant_i=1, no responses, ch1 requesting -> 4 grants, then request_o=0 until one response, then request_o=1 in the following cycle.
REQ-035 Routing: issue ch0 (addr 0x100), ch1 (0x200), ch0 (0x300), then responses with data 0xA, 0xB, 0xC -> response_ch0_o with 0xA, response_ch1_o with 0xB, response_ch0_o with 0xC.
REQ-036 Spurious response: response_i=1 with the FIFO empty -> both response flags 0; the next legal request/response pair routes correctly.
REQ-037 Reset mid-flight: 3 outstanding requests, assert rst for one cycle -> FIFO empty and priority ch0; 3 late responses are all dropped.
REQ-038 Stall: both channels request with grant_i=0 for 5 cycles -> no grants, no FIFO push, priority unchanged; addr_o stable at the priority channel's address.
